// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encoding, winner codes, ball centre and score helper
// Contents: state_t (IDLE..GAME_OVER), WIN_* codes, BALL_X0/BALL_Y0, sat_inc()
package pong_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      POINT      = 3'd3,
      GAME_OVER  = 3'd4
   } state_t;
   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;
   localparam int BALL_X0 = 320;
   localparam int BALL_Y0 = 240;
   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return s == 4'hf ? s : s + 4'd1;
   endfunction
endpackage

// File: rtl/pong_game_ctrl_tick_gen.sv
// tick_gen: free-running divider, one-cycle tick when the counter wraps at TICK_DIV-1
// Ports: clk, rst (sync clear), tick (high while counter == TICK_DIV-1)
module tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(TICK_DIV - 1);
   always_ff @(posedge clk)
      cnt <= rst || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer (idle, serve delay, play, point, game over) with scores
// Ports: clk, rst (sync, active-high), serve_btn, pause_sw, miss_l, miss_r in;
//        step, ball_center, serve_dir, score_l, score_r, winner, state out (all registered).
// Build option AUTO_SERVE_EN: serve delay ends on countdown expiry instead of a serve edge.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int SERVE_TICKS = 120,
   parameter int WIN_SCORE   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serve_btn,
   input  logic       pause_sw,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       step,
   output logic       ball_center,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [1:0] winner,
   output logic [2:0] state
);
   localparam int CW = $clog2(SERVE_TICKS + 2);
   state_t st;
   logic tick, btn_q, srv, go, credit_l, credit_r;
   logic [CW-1:0] cd;
   logic [3:0] nl, nr;
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
   assign srv   = serve_btn & ~btn_q;
   assign nl    = sat_inc(score_l);
   assign nr    = sat_inc(score_r);
   assign state = st;
`ifdef AUTO_SERVE_EN
   assign go = cd == '0;
`else
   // edges seen before expiry are simply lost
   assign go = cd == '0 && srv;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         btn_q       <= 1'b0;
         step        <= 1'b0;
         ball_center <= 1'b0;
         serve_dir   <= 1'b0;
         score_l     <= '0;
         score_r     <= '0;
         winner      <= WIN_NONE;
         cd          <= '0;
         credit_l    <= 1'b0;
         credit_r    <= 1'b0;
      end else begin
         btn_q       <= serve_btn;
         step        <= st == PLAY && tick && !pause_sw;
         ball_center <= 1'b0;
         case (st)
            IDLE, GAME_OVER: if (srv) begin
               score_l     <= '0;
               score_r     <= '0;
               winner      <= WIN_NONE;
               ball_center <= 1'b1;
               cd          <= CW'(SERVE_TICKS);
               st          <= SERVE_WAIT;
            end
            SERVE_WAIT:
               if (go) st <= PLAY;
               else if (tick && !pause_sw && cd != '0) cd <= cd - 1'b1;
            PLAY: if (miss_l || miss_r) begin
               // simultaneous misses reach POINT with neither side credited
               credit_l <= miss_r & ~miss_l;
               credit_r <= miss_l & ~miss_r;
               st       <= POINT;
            end
            POINT: begin
               ball_center <= 1'b1;
               cd          <= CW'(SERVE_TICKS);
               st          <= SERVE_WAIT;
               if (credit_l) begin
                  score_l   <= nl;
                  serve_dir <= 1'b0;
                  if (nl == 4'(WIN_SCORE)) begin
                     winner <= WIN_LEFT;
                     st     <= GAME_OVER;
                  end
               end else if (credit_r) begin
                  score_r   <= nr;
                  serve_dir <= 1'b1;
                  if (nr == 4'(WIN_SCORE)) begin
                     winner <= WIN_RIGHT;
                     st     <= GAME_OVER;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench with a ball_center scoreboard
module tb_pong_game_ctrl;
   localparam logic [2:0] S_IDLE = 3'd0, S_SW = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_GO = 3'd4;
   typedef struct {
      logic [3:0] sl;
      logic [3:0] sr;
      logic [1:0] w;
      logic       dir;
      logic [2:0] st;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, serve_btn = 1'b0, pause_sw = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
   logic step, ball_center, serve_dir;
   logic [3:0] score_l, score_r;
   logic [1:0] winner;
   logic [2:0] state;
   exp_t q[$];
   int tests = 0, fails = 0, step_cnt = 0;
   pong_game_ctrl #(.TICK_DIV(4), .SERVE_TICKS(3), .WIN_SCORE(3)) dut (
      .clk(clk), .rst(rst), .serve_btn(serve_btn), .pause_sw(pause_sw),
      .miss_l(miss_l), .miss_r(miss_r), .step(step), .ball_center(ball_center),
      .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
      .winner(winner), .state(state)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (step) step_cnt++;
      if (ball_center) begin
         exp_t e;
         chk("bc_expected", q.size() > 0, 1'b1);
         chk("bc_no_step", step, 1'b0);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("bc_score_l", score_l, e.sl);
            chk("bc_score_r", score_r, e.sr);
            chk("bc_winner", winner, e.w);
            chk("bc_dir", serve_dir, e.dir);
            chk("bc_state", state, e.st);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse_serve;
      serve_btn = 1'b1;
      @(negedge clk);
      serve_btn = 1'b0;
   endtask
   task automatic wait_state(input logic [2:0] s, input int lim, output int n);
      n = 0;
      while (state !== s && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic go_play;
`ifdef AUTO_SERVE_EN
      int n;
      wait_state(S_PLAY, 20, n);
`else
      cyc(16);
      pulse_serve;
`endif
      chk("go_play", state, S_PLAY);
   endtask
   task automatic point(input logic ml, input logic mr, input exp_t e);
      q.push_back(e);
      miss_l = ml;
      miss_r = mr;
      @(negedge clk);
      miss_l = 1'b0;
      miss_r = 1'b0;
      chk("point_state", state, S_POINT);
      chk("point_no_bc", ball_center, 1'b0);
      @(negedge clk);
      chk("point_next", state, e.st);
   endtask
   initial begin
      int n;
      int s0;
      cyc(3);
      chk("rst_state", state, S_IDLE);
      chk("rst_step", step, 1'b0);
      chk("rst_bc", ball_center, 1'b0);
      chk("rst_dir", serve_dir, 1'b0);
      chk("rst_scores", {score_l, score_r}, 8'h00);
      chk("rst_winner", winner, 2'b00);
      rst = 1'b0;
      cyc(2);
      q.push_back('{4'd0, 4'd0, 2'b00, 1'b0, S_SW});
      pulse_serve;
      chk("serve_sw", state, S_SW);
`ifdef AUTO_SERVE_EN
      wait_state(S_PLAY, 20, n);
      chk("auto_delay", n >= 10 && n <= 13, 1'b1);
`else
      cyc(6);
      pulse_serve;
      chk("early_serve_ignored", state, S_SW);
      cyc(16);
      pulse_serve;
`endif
      chk("play_entry", state, S_PLAY);
      n = 0;
      while (!step && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("first_step_lat", n >= 1 && n <= 4, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!step && n < 10);
      chk("step_period", n, 4);
      point(1'b0, 1'b1, '{4'd1, 4'd0, 2'b00, 1'b0, S_SW});
      go_play;
      point(1'b1, 1'b0, '{4'd1, 4'd1, 2'b00, 1'b1, S_SW});
      go_play;
      point(1'b1, 1'b1, '{4'd1, 4'd1, 2'b00, 1'b1, S_SW});
      go_play;
      point(1'b0, 1'b1, '{4'd2, 4'd1, 2'b00, 1'b0, S_SW});
      go_play;
      point(1'b0, 1'b1, '{4'd3, 4'd1, 2'b01, 1'b0, S_GO});
      miss_r = 1'b1;
      @(negedge clk);
      miss_r = 1'b0;
      miss_l = 1'b1;
      @(negedge clk);
      miss_l = 1'b0;
      cyc(2);
      chk("go_hold_state", state, S_GO);
      chk("go_hold_scores", {score_l, score_r}, 8'h31);
      chk("go_hold_winner", winner, 2'b01);
      q.push_back('{4'd0, 4'd0, 2'b00, 1'b0, S_SW});
      pulse_serve;
      pause_sw = 1'b1;
      cyc(80);
      chk("pause_sw_state", state, S_SW);
      pause_sw = 1'b0;
`ifdef AUTO_SERVE_EN
      wait_state(S_PLAY, 20, n);
      chk("pause_sw_resume", n >= 10 && n <= 13, 1'b1);
`else
      cyc(2);
      pulse_serve;
      chk("pause_sw_frozen", state, S_SW);
      go_play;
`endif
      chk("pause_play_entry", state, S_PLAY);
      pause_sw = 1'b1;
      @(negedge clk);
      s0 = step_cnt;
      cyc(80);
      chk("pause_play_steps", step_cnt - s0, 0);
      chk("pause_play_state", state, S_PLAY);
      pause_sw = 1'b0;
      n = 0;
      while (!step && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("unpause_step", step, 1'b1);
      point(1'b1, 1'b0, '{4'd0, 4'd1, 2'b00, 1'b1, S_SW});
      go_play;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_state", state, S_IDLE);
      chk("mid_rst_scores", {score_l, score_r}, 8'h00);
      chk("mid_rst_dir", serve_dir, 1'b0);
      chk("mid_rst_step", step, 1'b0);
      chk("mid_rst_bc", ball_center, 1'b0);
      chk("mid_rst_winner", winner, 2'b00);
      rst = 1'b0;
      cyc(2);
      chk("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the two-player pong design. It derives the game-tick enable from the 25 MHz pixel clock and runs the match state machine: idle, serve delay, play, point scored, game over. It owns the two 4-bit scores and tells the ball datapath when to step, when to re-centre, and which way to serve. It sits between the key/switch inputs, the ball/paddle logic, and the BCD/seven-segment score display.

## Interface
Parameters:
- TICK_DIV, 50000: pixel-clock cycles per game tick (one ball/paddle step)
- SERVE_TICKS, 120: game ticks spent in SERVE_WAIT before play resumes
- WIN_SCORE, 9: score that ends the match; legal range 1..15

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous active-high reset
- serve_btn  in  1  serve/start request, active-high level (already inverted from KEY)
- pause_sw  in  1  level; 1 freezes the game
- miss_l  in  1  one-cycle pulse: ball passed the left edge (right player scores)
- miss_r  in  1  one-cycle pulse: ball passed the right edge (left player scores)
- step  out  1  one-cycle pulse per game tick while playing
- ball_center  out  1  one-cycle pulse: ball datapath reloads (320,240)
- serve_dir  out  1  0 = ball travels right, 1 = ball travels left
- score_l, score_r  out  4  binary scores
- winner  out  2  00 none, 01 left, 10 right
- state  out  3  current FSM state encoding

## Operation
- Tick generator: counter 0..TICK_DIV-1, free-running; `tick` is high for one cycle on wrap.
- `serve_btn` is rising-edge detected (registered previous value); only edges act.
- IDLE: on a serve edge, clear the scores and winner, pulse ball_center, and go to SERVE_WAIT.
- SERVE_WAIT: countdown of SERVE_TICKS on `tick`, frozen while pause_sw=1. The exit condition depends on the configuration (see below). On exit, go to PLAY.
- PLAY: step = tick & ~pause_sw.
  - miss_r alone: go to POINT and credit left.
  - miss_l alone: go to POINT and credit right.
  - Both in the same cycle: go to POINT with no score change and serve_dir unchanged.
- POINT (one cycle):
  - Increment the credited score, saturating at 15.
  - Pulse ball_center.
  - Set serve_dir toward the conceding player: left scored gives 0; right scored gives 1.
  - If the new score equals WIN_SCORE, set winner and go to GAME_OVER. Otherwise go to SERVE_WAIT and reload the countdown.
- GAME_OVER: scores and winner hold. A serve edge behaves exactly as in IDLE.
- Miss pulses outside PLAY are ignored. Serve edges in SERVE_WAIT, PLAY and POINT are ignored unless AUTO_SERVE_EN is off (see below).
- pause_sw never changes state; it only gates step and the serve countdown.

## Timing
- Reset values: state IDLE, step 0, ball_center 0, serve_dir 0, scores 0, winner 00, tick counter 0, edge register 0.
- Reset asserted mid-match takes effect on the next clk edge and discards any pending POINT.
- A miss pulse in PLAY at cycle n puts the FSM in POINT at n+1. Scores, ball_center and serve_dir update at n+2; the next state (SERVE_WAIT or GAME_OVER) is also reached at n+2.
- step is registered and coincides with the cycle after `tick`. It is never asserted in the same cycle as ball_center.
- The first step after serve occurs on the first tick after the PLAY entry.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- AUTO_SERVE_EN defined: SERVE_WAIT exits when the countdown reaches 0; serve_btn is ignored there.
- AUTO_SERVE_EN undefined: SERVE_WAIT exits only on a serve edge received after the countdown reaches 0. Earlier edges are dropped, not queued.

## Structure
- Shared package pong_pkg holds:
  - the state enum: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4
  - the winner codes
  - localparams for the ball centre coordinates 320/240
- One sub-module, tick_gen, parameterised by TICK_DIV, with outputs `tick` and clear input `rst`. The FSM, edge detect and scores live in pong_game_ctrl.

## Test plan
- Reset, then a serve edge: state goes IDLE→SERVE_WAIT with one ball_center pulse. With TICK_DIV=4, SERVE_TICKS=3 and AUTO_SERVE_EN, PLAY is entered after 12 clks and step then pulses every 4 clks.
- In PLAY, pulse miss_r: score_l goes 0→1, serve_dir=0, one ball_center pulse, back in SERVE_WAIT. Then pulse miss_l: score_r=1, serve_dir=1.
- With WIN_SCORE=3, play to score_l=3: winner=01, state GAME_OVER. Further misses leave the scores unchanged. A serve edge clears the scores to 0/0 and winner to 00.
- miss_l and miss_r in the same cycle: scores unchanged, ball_center pulses, SERVE_WAIT entered.
- pause_sw=1 for 20 ticks in PLAY and in SERVE_WAIT: no step pulses and the countdown is frozen. Release resumes the countdown from the held value.
- AUTO_SERVE_EN undefined: a serve edge mid-countdown is ignored. An edge after the countdown expires enters PLAY. Asserting rst in PLAY returns all outputs to reset values on the next clk.
